// File: rtl/sap_ctrl_pkg.sv
// Shared control-word definitions for the 8-bit bus CPU.
// Used by the sequencer and the RAM programmer.
package sap_ctrl_pkg;

  localparam int CW_W = 15;

  localparam int B_CP    = 14;
  localparam int B_EP    = 13;
  localparam int B_LP    = 12;
  localparam int B_LMA_N = 11;
  localparam int B_LMD_N = 10;
  localparam int B_CE_N  = 9;
  localparam int B_LR_N  = 8;
  localparam int B_LI_N  = 7;
  localparam int B_EI_N  = 6;
  localparam int B_LA_N  = 5;
  localparam int B_EA    = 4;
  localparam int B_SU    = 3;
  localparam int B_EU    = 2;
  localparam int B_LB_N  = 1;
  localparam int B_LO_N  = 0;

  typedef logic [CW_W-1:0] cw_t;

  // every active-low control high, every active-high control low
  localparam cw_t IDLE_CW = 15'h0FE3;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0     = 3'd0,
    T1     = 3'd1,
    T2     = 3'd2,
    T3     = 3'd3,
    T4     = 3'd4,
    T5     = 3'd5,
    S_IDLE = 3'd6
  } stage_t;

  typedef enum logic [1:0] {
    M_RUN   = 2'd0,
    M_DRAIN = 2'd1,
    M_PROG  = 2'd2,
    M_HALT  = 2'd3
  } mode_t;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for a single asynchronous level.
// Depth is a parameter and must be at least 2.
module sync_2ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr <= '0;
    end else begin
      sr <= {sr[DEPTH-2:0], d};
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/cpu_sequencer.sv
// T0-T5 micro-sequencer, opcode decode and control-word
// arbitration between the CPU and the RAM programmer.
module cpu_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  opcode,
  input  logic        programming,
  input  logic [14:0] prog_ctrl,
  output logic [14:0] ctrl,
  output logic [2:0]  stage,
  output logic        prog_grant,
  output logic        hlt
);

  function automatic cw_t decode(stage_t st, logic [3:0] op);
    cw_t cw;
    cw = IDLE_CW;
    case (st)
      T0: begin
        cw[B_EP]    = 1'b1;
        cw[B_LMA_N] = 1'b0;
      end
      T1: cw[B_CP] = 1'b1;
      T2: begin
        cw[B_CE_N] = 1'b0;
        cw[B_LI_N] = 1'b0;
      end
      T3: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw[B_EI_N]  = 1'b0;
            cw[B_LMA_N] = 1'b0;
          end
          OP_JMP: begin
            cw[B_EI_N] = 1'b0;
            cw[B_LP]   = 1'b1;
          end
          OP_OUT: begin
            cw[B_EA]   = 1'b1;
            cw[B_LO_N] = 1'b0;
          end
          default: ;
        endcase
      end
      T4: begin
        case (op)
          OP_LDA: begin
            cw[B_CE_N] = 1'b0;
            cw[B_LA_N] = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            cw[B_CE_N] = 1'b0;
            cw[B_LB_N] = 1'b0;
          end
          default: ;
        endcase
      end
      T5: begin
        case (op)
          OP_ADD: begin
            cw[B_EU]   = 1'b1;
            cw[B_LA_N] = 1'b0;
          end
          OP_SUB: begin
            cw[B_SU]   = 1'b1;
            cw[B_EU]   = 1'b1;
            cw[B_LA_N] = 1'b0;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    return cw;
  endfunction

  logic   req;
  mode_t  mode_q;
  stage_t stage_q;
  logic   grant_q;
  logic   hlt_q;
  cw_t    ctrl_q;

  logic stage_ok;
  logic boundary;
  logic hlt_end;

  sync_2ff #(
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .resetn(resetn),
    .d     (programming),
    .q     (req)
  );

  assign stage_ok = (stage_q <= S_IDLE);
  assign boundary = (stage_q == T5) || (stage_q == S_IDLE);
  assign hlt_end  = (stage_q == T3) && (opcode == OP_HLT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q  <= M_RUN;
      stage_q <= S_IDLE;
      grant_q <= 1'b0;
      hlt_q   <= 1'b0;
    end else begin
      grant_q <= 1'b0;
      hlt_q   <= 1'b0;
      case (mode_q)
        M_RUN, M_DRAIN: begin
          if (!stage_ok) begin
            mode_q  <= M_RUN;
            stage_q <= S_IDLE;
          end else if (hlt_end) begin
            mode_q  <= M_HALT;
            stage_q <= S_IDLE;
            hlt_q   <= 1'b1;
          end else if (boundary && req) begin
            mode_q  <= M_PROG;
            stage_q <= S_IDLE;
            grant_q <= 1'b1;
          end else if (boundary) begin
            // a request that fell while draining resumes without a grant
            mode_q  <= M_RUN;
            stage_q <= T0;
          end else begin
            stage_q <= stage_t'(stage_q + 3'd1);
            if (req) mode_q <= M_DRAIN;
          end
        end
        M_PROG: begin
          if (req) begin
            stage_q <= S_IDLE;
            grant_q <= 1'b1;
          end else begin
            mode_q  <= M_RUN;
            stage_q <= T0;
          end
        end
        M_HALT: begin
          stage_q <= S_IDLE;
          if (req) begin
            mode_q  <= M_PROG;
            grant_q <= 1'b1;
          end else begin
            hlt_q <= 1'b1;
          end
        end
        default: begin
          mode_q  <= M_RUN;
          stage_q <= S_IDLE;
        end
      endcase
    end
  end

  // half-cycle setup so the word is stable at the datapath posedge
  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_q <= IDLE_CW;
    end else begin
      ctrl_q <= decode(stage_q, opcode);
    end
  end

  assign ctrl       = grant_q ? prog_ctrl : ctrl_q;
  assign stage      = stage_q;
  assign prog_grant = grant_q;
  assign hlt        = hlt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: expected control words
// are queued per instruction and popped as each stage executes.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        programming = 1'b0;
  logic [14:0] prog_ctrl = 15'h0;
  logic [14:0] ctrl;
  logic [2:0]  stage;
  logic        prog_grant;
  logic        hlt;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];

  cpu_sequencer #(
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .opcode     (opcode),
    .programming(programming),
    .prog_ctrl  (prog_ctrl),
    .ctrl       (ctrl),
    .stage      (stage),
    .prog_grant (prog_grant),
    .hlt        (hlt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [14:0] model(int st, logic [3:0] op);
    logic [14:0] w;
    w = 15'h0FE3;
    case (st)
      0: w = 15'h27E3;
      1: w = 15'h4FE3;
      2: w = 15'h0D63;
      3: case (op)
        4'h0, 4'h1, 4'h2: w = 15'h07A3;
        4'h3: w = 15'h1FA3;
        4'hE: w = 15'h0FF2;
        default: w = 15'h0FE3;
      endcase
      4: case (op)
        4'h0: w = 15'h0DC3;
        4'h1, 4'h2: w = 15'h0DE1;
        default: w = 15'h0FE3;
      endcase
      5: case (op)
        4'h1: w = 15'h0FC7;
        4'h2: w = 15'h0FCF;
        default: w = 15'h0FE3;
      endcase
      default: w = 15'h0FE3;
    endcase
    return w;
  endfunction

  task automatic run_instr(input logic [3:0] op, input bit started,
                           input int req_at, input int drop_at);
    int n;
    logic [14:0] exp;
    n = (op == 4'hF) ? 4 : 6;
    opcode = op;
    for (int i = 0; i < n; i++) exp_q.push_back(model(i, op));
    for (int i = 0; i < n; i++) begin
      if (!(started && i == 0)) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (stage !== 3'(i) || prog_grant !== 1'b0) begin
        errors++;
        $display("FAIL stage op%0h t%0d: stage=%0d grant=%b need stage=%0d grant=0",
                 op, i, stage, prog_grant, i);
      end
      if (i == req_at) programming = 1'b1;
      if (i == drop_at) programming = 1'b0;
      @(negedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (ctrl !== exp) begin
        errors++;
        $display("FAIL ctrl op%0h t%0d: got %h need %h", op, i, ctrl, exp);
      end
    end
  endtask

  task automatic wait_resume(input string name);
    int k;
    programming = 1'b0;
    k = 0;
    while (prog_grant !== 1'b0 && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (prog_grant !== 1'b0 || stage !== 3'd0) begin
      errors++;
      $display("FAIL %s resume: grant=%b stage=%0d need grant=0 stage=0",
               name, prog_grant, stage);
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (stage !== 3'd6 || ctrl !== 15'h0FE3 || prog_grant !== 1'b0 || hlt !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: stage=%0d ctrl=%h grant=%b hlt=%b need 6/0fe3/0/0",
               stage, ctrl, prog_grant, hlt);
    end
    @(negedge clk);
    #1;
    resetn = 1'b1;
    opcode = 4'h0;
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (stage !== 3'd6 || ctrl !== 15'h0FE3 || prog_grant !== 1'b0 || hlt !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_t4: stage=%0d ctrl=%h grant=%b hlt=%b need 6/0fe3/0/0",
               stage, ctrl, prog_grant, hlt);
    end
    @(negedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_lda;
    run_instr(4'h0, 1'b0, -1, -1);
  endtask

  task automatic test_back_to_back;
    run_instr(4'h1, 1'b0, -1, -1);
    run_instr(4'h2, 1'b0, -1, -1);
    run_instr(4'h3, 1'b0, -1, -1);
    run_instr(4'hE, 1'b0, -1, -1);
    run_instr(4'h7, 1'b0, -1, -1);
  endtask

  task automatic test_drain;
    run_instr(4'h1, 1'b0, 1, -1);
    @(posedge clk);
    #1;
    checks++;
    if (prog_grant !== 1'b1 || stage !== 3'd6) begin
      errors++;
      $display("FAIL drain_grant: grant=%b stage=%0d need 1/6", prog_grant, stage);
    end
    prog_ctrl = 15'h0EE3;
    #1;
    checks++;
    if (ctrl !== 15'h0EE3) begin
      errors++;
      $display("FAIL drain_mirror: got %h need 0ee3", ctrl);
    end
    wait_resume("drain");
    run_instr(4'h1, 1'b1, -1, -1);
  endtask

  task automatic test_drop_in_drain;
    run_instr(4'h0, 1'b0, 0, 3);
    run_instr(4'h2, 1'b0, -1, -1);
  endtask

  task automatic test_hlt;
    run_instr(4'hF, 1'b0, -1, -1);
    @(posedge clk);
    #1;
    checks++;
    if (hlt !== 1'b1 || stage !== 3'd6) begin
      errors++;
      $display("FAIL hlt_enter: hlt=%b stage=%0d need 1/6", hlt, stage);
    end
    repeat (20) begin
      @(negedge clk);
      #1;
      checks++;
      if (hlt !== 1'b1 || stage !== 3'd6 || ctrl !== 15'h0FE3) begin
        errors++;
        $display("FAIL hlt_hold: hlt=%b stage=%0d ctrl=%h need 1/6/0fe3",
                 hlt, stage, ctrl);
      end
    end
  endtask

  task automatic test_prog_from_halt;
    int k;
    programming = 1'b1;
    k = 0;
    while (prog_grant !== 1'b1 && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (prog_grant !== 1'b1 || hlt !== 1'b0 || stage !== 3'd6) begin
      errors++;
      $display("FAIL halt_prog: grant=%b hlt=%b stage=%0d need 1/0/6",
               prog_grant, hlt, stage);
    end
    prog_ctrl = 15'h0EE3;
    #1;
    checks++;
    if (ctrl !== 15'h0EE3) begin
      errors++;
      $display("FAIL halt_mirror_a: got %h need 0ee3", ctrl);
    end
    prog_ctrl = 15'h5A5A;
    #1;
    checks++;
    if (ctrl !== 15'h5A5A) begin
      errors++;
      $display("FAIL halt_mirror_b: got %h need 5a5a", ctrl);
    end
    wait_resume("halt");
    checks++;
    if (hlt !== 1'b0) begin
      errors++;
      $display("FAIL halt_cleared: hlt=%b need 0", hlt);
    end
    run_instr(4'h0, 1'b1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_lda();
    test_back_to_back();
    test_drain();
    test_drop_in_drain();
    test_hlt();
    test_prog_from_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
